// File: rtl/sig_align_if.sv
// Handshake and data bundle for the significand alignment stage.
// The master side is upstream/downstream logic; the slave side is sig_align.
interface sig_align_if #(
    parameter int unsigned EXP_W = 11,
    parameter int unsigned SIG_W = 53
) ();
    logic               in_valid;
    logic               in_ready;
    logic [EXP_W-1:0]   ea;
    logic [EXP_W-1:0]   eb;
    logic [SIG_W-1:0]   fa;
    logic [SIG_W-1:0]   fb;
    logic               eb_gt_ea;
    logic [EXP_W-1:0]   as;
    logic               out_valid;
    logic               out_ready;
    logic [EXP_W-1:0]   e_out;
    logic [SIG_W+2:0]   fl_out;
    logic [SIG_W+2:0]   fs_out;
    logic               swap_out;

    modport master (
        output in_valid, ea, eb, fa, fb, eb_gt_ea, as, out_ready,
        input  in_ready, out_valid, e_out, fl_out, fs_out, swap_out
    );

    modport slave (
        input  in_valid, ea, eb, fa, fb, eb_gt_ea, as, out_ready,
        output in_ready, out_valid, e_out, fl_out, fs_out, swap_out
    );
endinterface

// File: rtl/sig_align.sv
// FP adder significand alignment: 2-stage elastic pipeline producing {f,g,r,s}.
// Optional SIG_ALIGN_FLUSH_EN adds a synchronous flush that empties both stages.
module sig_align #(
    parameter int unsigned EXP_W = 11,
    parameter int unsigned SIG_W = 53
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SIG_ALIGN_FLUSH_EN
    input  logic flush,
`endif
    sig_align_if.slave bus
);
    localparam int unsigned EXT_W = SIG_W + 3;
    localparam int unsigned SH_W  = $clog2(EXT_W + 1);

    logic               kill;
    logic               in_ready;
    logic               load1;
    logic               adv2;
    logic [SH_W-1:0]    sh_sat;

    logic               v1;
    logic [EXP_W-1:0]   e1;
    logic               swap1;
    logic [SIG_W-1:0]   fl1;
    logic [SIG_W-1:0]   fs1;
    logic [SH_W-1:0]    sh1;

    logic               v2;
    logic [EXP_W-1:0]   e2;
    logic               swap2;
    logic [EXT_W-1:0]   fl2;
    logic [EXT_W-1:0]   fs2;

    logic [EXT_W-1:0]   ext;
    logic [EXT_W-1:0]   shifted;
    logic [EXT_W-1:0]   lost;
    logic [EXT_W-1:0]   fs_next;

`ifdef SIG_ALIGN_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    always_comb begin
        in_ready = !kill && (!v1 || !v2 || bus.out_ready);
        load1    = bus.in_valid && in_ready;
        adv2     = !kill && v1 && (!v2 || bus.out_ready);
        if (32'(bus.as) >= EXT_W)
            sh_sat = SH_W'(EXT_W);
        else
            sh_sat = SH_W'(bus.as);
    end

    // Sticky collects every bit of the extended significand pushed past bit 0.
    always_comb begin
        ext     = {fs1, 3'b000};
        shifted = ext >> sh1;
        lost    = ext & ~({EXT_W{1'b1}} << sh1);
        fs_next = {shifted[EXT_W-1:1], shifted[0] | (|lost)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (kill) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (load1)
                v1 <= 1'b1;
            else if (adv2)
                v1 <= 1'b0;
            if (adv2)
                v2 <= 1'b1;
            else if (bus.out_ready)
                v2 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1    <= '0;
            swap1 <= 1'b0;
            fl1   <= '0;
            fs1   <= '0;
            sh1   <= '0;
            e2    <= '0;
            swap2 <= 1'b0;
            fl2   <= '0;
            fs2   <= '0;
        end else begin
            if (load1) begin
                swap1 <= bus.eb_gt_ea;
                sh1   <= sh_sat;
                if (bus.eb_gt_ea) begin
                    e1  <= bus.eb;
                    fl1 <= bus.fb;
                    fs1 <= bus.fa;
                end else begin
                    e1  <= bus.ea;
                    fl1 <= bus.fa;
                    fs1 <= bus.fb;
                end
            end
            if (adv2) begin
                e2    <= e1;
                swap2 <= swap1;
                fl2   <= {fl1, 3'b000};
                fs2   <= fs_next;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v2;
    assign bus.e_out     = e2;
    assign bus.fl_out    = fl2;
    assign bus.fs_out    = fs2;
    assign bus.swap_out  = swap2;
endmodule
